// File: rtl/adc_pkg.sv
// adc_pkg
// Shared definitions for the SPI ADC capture block:
//   frame_state_t : capture FSM states
//   F             : default frame length in SCLK bits (leading zeros + data)
//   to_twos       : offset-binary to two's-complement conversion
package adc_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} frame_state_t;

    localparam int SAMPLE_W_DEF   = 12;
    localparam int LEAD_ZEROS_DEF = 4;
    localparam int F              = LEAD_ZEROS_DEF + SAMPLE_W_DEF;

    // Offset binary differs from two's complement only in the MSB, so the
    // conversion is a single bit flip at position width-1.
    function automatic logic [31:0] to_twos(input logic [31:0] raw,
                                            input int          width,
                                            input bit          offset_binary);
        logic [31:0] msb;
        msb = 32'd1 << (width - 1);
        return offset_binary ? (raw ^ msb) : raw;
    endfunction

endpackage

// File: rtl/adc_spi_capture_sclk_gen.sv
// sclk_gen
// SCLK timing for one SPI frame. The frame is a sequence of half-periods,
// each clk_div clk cycles long: half 0 is the chip-select setup (SCLK high),
// then odd halves drive SCLK low and even halves drive it high.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   busy       : high while chip select is asserted; counters clear otherwise
//   adc_sclk   : serial clock, high when idle
//   rise       : strobe on the clk edge that drives SCLK 0->1 (capture point)
//   setup_end  : strobe on the edge that ends the setup half
//   last_bit   : strobe on the edge that ends the high half of the final bit
module sclk_gen
#(
    parameter int clk_div    = 4,
    parameter int half_count = 33
) (
    input  logic clk,
    input  logic rst,
    input  logic busy,
    output logic adc_sclk,
    output logic rise,
    output logic setup_end,
    output logic last_bit
);

    localparam int div_w = (clk_div > 1) ? $clog2(clk_div) : 1;
    localparam int idx_w = $clog2(half_count);

    logic [div_w-1:0] half_cnt;
    logic [idx_w-1:0] half_idx;
    logic             half_end;

    assign half_end = busy && (half_cnt == div_w'(clk_div - 1));

    always_ff @(posedge clk) begin
        if (rst || !busy) begin
            half_cnt <= '0;
            half_idx <= '0;
        end else if (half_end) begin
            half_cnt <= '0;
            // Wrap at the end of the frame so SCLK is already high in DONE.
            half_idx <= (half_idx == idx_w'(half_count - 1)) ? '0 : half_idx + 1'b1;
        end else begin
            half_cnt <= half_cnt + 1'b1;
        end
    end

    assign adc_sclk  = ~half_idx[0];
    assign rise      = half_end && half_idx[0];
    assign setup_end = half_end && (half_idx == '0);
    assign last_bit  = half_end && (half_idx == idx_w'(half_count - 1));

endmodule

// File: rtl/adc_spi_capture.sv
// adc_spi_capture
// Drives a serial SPI ADC at a fixed sample rate, deserialises each frame
// (lead_zeros leading zeros, then sample_width data bits, MSB first) and
// emits a two's-complement sample with a one-cycle valid strobe.
// Ports:
//   clk, rst      : system clock, synchronous active-high reset
//   enable        : start new frames while high (sampled at period start)
//   adc_miso      : serial data from the ADC
//   adc_cs_n      : chip select, active low
//   adc_sclk      : serial clock, idles high
//   sample        : signed sample, holds between frames
//   sample_valid  : one-cycle strobe when sample is updated
//   frame_err     : sticky, set when a leading bit was nonzero
module adc_spi_capture
    import adc_pkg::*;
#(
    parameter int sample_width  = 12,
    parameter int lead_zeros    = 4,
    parameter int clk_div       = 4,
    parameter int sample_period = 1042,
    parameter bit offset_binary = 1'b1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           enable,
    input  logic                           adc_miso,
    output logic                           adc_cs_n,
    output logic                           adc_sclk,
    output logic signed [sample_width-1:0] sample,
    output logic                           sample_valid,
    output logic                           frame_err
);

    localparam int frame_bits = lead_zeros + sample_width;
    localparam int cnt_w      = $clog2(sample_period);

    if (clk_div < 1) begin : g_div_check
        $error("clk_div must be at least 1");
    end
    if (sample_period < clk_div * (2 * frame_bits + 1) + 2) begin : g_period_check
        $error("sample_period too short to fit one frame");
    end

    frame_state_t            state, state_nxt;
    logic [cnt_w-1:0]        period_cnt;
    logic [frame_bits-1:0]   shift_reg;
    logic [31:0]             converted;
    logic                    tick, busy, rise, setup_end, last_bit;

    // Free-running period counter; frames may only start at its zero point.
    always_ff @(posedge clk) begin
        if (rst || period_cnt == cnt_w'(sample_period - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    assign tick = (period_cnt == '0) && enable;
    assign busy = (state == SETUP) || (state == SHIFT);

    sclk_gen #(
        .clk_div    (clk_div),
        .half_count (2 * frame_bits + 1)
    ) u_sclk_gen (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .adc_sclk  (adc_sclk),
        .rise      (rise),
        .setup_end (setup_end),
        .last_bit  (last_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A tick outside IDLE is simply ignored.
    always_comb begin
        state_nxt    = state;
        adc_cs_n     = 1'b1;
        sample_valid = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) state_nxt = SETUP;
            end
            SETUP: begin
                adc_cs_n = 1'b0;
                if (setup_end) state_nxt = SHIFT;
            end
            SHIFT: begin
                adc_cs_n = 1'b0;
                if (last_bit) state_nxt = DONE;
            end
            DONE: begin
                sample_valid = 1'b1;
                state_nxt    = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign converted = to_twos(32'(shift_reg[sample_width-1:0]), sample_width, offset_binary);

    // Sample and error flag load on the SHIFT->DONE edge, so both are
    // visible in the DONE cycle alongside sample_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            sample    <= '0;
            frame_err <= 1'b0;
        end else begin
            if (rise) begin
                shift_reg <= {shift_reg[frame_bits-2:0], adc_miso};
            end
            if (state == SHIFT && last_bit) begin
                sample <= $signed(converted[sample_width-1:0]);
                if (|shift_reg[frame_bits-1 -: lead_zeros]) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_spi_capture.sv
`timescale 1ns/1ps
module tb_adc_spi_capture;

    localparam int P1 = 100;
    localparam int D1 = 2;
    localparam int P2 = 50;
    localparam int D2 = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic enable2 = 1'b0;
    logic miso = 1'b0;
    logic miso2 = 1'b0;
    logic cs_n, sclk, valid, ferr;
    logic cs_n2, sclk2, valid2, ferr2;
    logic signed [11:0] sample, sample2;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int mcnt = 0;

    logic [15:0] frame_q[$];
    logic [15:0] frame_q2[$];
    logic [11:0] exp_q[$];
    logic [11:0] exp_q2[$];

    adc_spi_capture #(
        .sample_width(12), .lead_zeros(4), .clk_div(D1),
        .sample_period(P1), .offset_binary(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .adc_miso(miso),
        .adc_cs_n(cs_n), .adc_sclk(sclk), .sample(sample),
        .sample_valid(valid), .frame_err(ferr)
    );

    adc_spi_capture #(
        .sample_width(12), .lead_zeros(4), .clk_div(D2),
        .sample_period(P2), .offset_binary(1'b0)
    ) dut2 (
        .clk(clk), .rst(rst), .enable(enable2), .adc_miso(miso2),
        .adc_cs_n(cs_n2), .adc_sclk(sclk2), .sample(sample2),
        .sample_valid(valid2), .frame_err(ferr2)
    );

    always #5 clk = ~clk;

    // Reference period counter: counter value after each edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst || mcnt == P1 - 1) mcnt <= 0;
        else mcnt <= mcnt + 1;
    end

    // ADC models: a frame word is taken at chip-select fall (expected sample
    // queued then), and one bit is shifted out after each SCLK falling edge.
    logic [15:0] word1 = 16'h0;
    int nfall1 = 0;
    logic prev_cs1 = 1'b1, prev_sclk1 = 1'b1;
    always @(negedge clk) begin
        if (cs_n) begin
            nfall1 = 0;
            miso = 1'b0;
        end else if (prev_cs1) begin
            if (frame_q.size() > 0) word1 = frame_q.pop_front();
            else word1 = 16'h0000;
            exp_q.push_back(word1[11:0] ^ 12'h800);
        end else if (prev_sclk1 && !sclk && nfall1 < 16) begin
            miso = word1[15 - nfall1];
            nfall1++;
        end
        prev_cs1 = cs_n;
        prev_sclk1 = sclk;
    end

    logic [15:0] word2 = 16'h0;
    int nfall2 = 0;
    logic prev_cs2 = 1'b1, prev_sclk2 = 1'b1;
    always @(negedge clk) begin
        if (cs_n2) begin
            nfall2 = 0;
            miso2 = 1'b0;
        end else if (prev_cs2) begin
            if (frame_q2.size() > 0) word2 = frame_q2.pop_front();
            else word2 = 16'h0000;
            exp_q2.push_back(word2[11:0]);
        end else if (prev_sclk2 && !sclk2 && nfall2 < 16) begin
            miso2 = word2[15 - nfall2];
            nfall2++;
        end
        prev_cs2 = cs_n2;
        prev_sclk2 = sclk2;
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_cs_fall(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!cs_n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL reset_cs_n: got %b want 1", cs_n); end
        vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL reset_sclk: got %b want 1", sclk); end
        vectors++; if (sample !== 12'h000) begin miscompares++; $display("FAIL reset_sample: got %h want 000", sample); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid); end
        vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", ferr); end
    endtask

    int last_vcyc = 0;

    task automatic test_frame_timing();
        bit ok;
        int low, rises;
        logic prev;
        logic [11:0] exp;
        frame_q.push_back(16'h0800);
        rst = 1'b0;
        enable = 1'b1;
        wait_cs_fall(ok);
        vectors++;
        if (!ok || mcnt != 1) begin
            miscompares++; $display("FAIL cs_fall_phase: got found=%0d cnt=%0d want found=1 cnt=1", ok, mcnt);
        end
        low = 1; rises = 0; prev = sclk;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cs_n) break;
            low++;
            if (sclk && !prev) rises++;
            prev = sclk;
        end
        vectors++; if (low != 66) begin miscompares++; $display("FAIL cs_low_cycles: got %0d want 66", low); end
        vectors++; if (rises != 16) begin miscompares++; $display("FAIL sclk_rises: got %0d want 16", rises); end
        vectors++; if (valid !== 1'b1) begin miscompares++; $display("FAIL valid_at_cs_rise: got %b want 1", valid); end
        exp = 12'hxxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++; if (sample !== exp) begin miscompares++; $display("FAIL first_sample: got %h want %h", sample, exp); end
        last_vcyc = cyc;
    endtask

    task automatic test_samples();
        bit ok;
        logic [15:0] raw[4];
        logic [15:0] ext_exp[4];
        logic [15:0] ext;
        logic [11:0] exp;
        raw = '{16'h0800, 16'h0FFF, 16'h0000, 16'h07FF};
        ext_exp = '{16'h0000, 16'h07FF, 16'hF800, 16'hFFFF};
        for (int i = 0; i < 4; i++) frame_q.push_back(raw[i]);
        for (int i = 0; i < 4; i++) begin
            wait_valid(ok);
            if (!ok) begin
                vectors++; miscompares++;
                $display("FAIL sample_%0d_timeout: got no strobe want strobe", i);
            end else begin
                exp = 12'hxxx;
                if (exp_q.size() > 0) exp = exp_q.pop_front();
                ext = {{4{sample[11]}}, sample};
                vectors++; if (sample !== exp) begin miscompares++; $display("FAIL sample_%0d: got %h want %h", i, sample, exp); end
                vectors++; if (ext !== ext_exp[i]) begin miscompares++; $display("FAIL expand_%0d: got %h want %h", i, ext, ext_exp[i]); end
                vectors++; if (cyc - last_vcyc != P1) begin miscompares++; $display("FAIL valid_interval_%0d: got %0d want %0d", i, cyc - last_vcyc, P1); end
                last_vcyc = cyc;
            end
        end
    endtask

    task automatic test_frame_err();
        bit ok;
        logic [11:0] exp;
        frame_q.push_back(16'h4123);
        frame_q.push_back(16'h0555);
        for (int i = 0; i < 2; i++) begin
            wait_valid(ok);
            exp = 12'hxxx;
            if (exp_q.size() > 0) exp = exp_q.pop_front();
            vectors++; if (!ok || sample !== exp) begin miscompares++; $display("FAIL err_sample_%0d: got %h want %h", i, sample, exp); end
            vectors++; if (ferr !== 1'b1) begin miscompares++; $display("FAIL frame_err_%0d: got %b want 1", i, ferr); end
        end
    endtask

    task automatic test_enable_midframe();
        bit ok;
        int low;
        logic [11:0] exp;
        frame_q.push_back(16'h0ABC);
        wait_cs_fall(ok);
        for (int i = 0; i < 200 && mcnt != 30; i++) @(negedge clk);
        enable = 1'b0;
        wait_valid(ok);
        exp = 12'hxxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++; if (!ok || sample !== exp) begin miscompares++; $display("FAIL disabled_frame_sample: got %h want %h", sample, exp); end
        low = 0;
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            if (!cs_n) low++;
        end
        vectors++; if (low != 0) begin miscompares++; $display("FAIL cs_while_disabled: got %0d low cycles want 0", low); end
        for (int i = 0; i < 200 && mcnt != 50; i++) @(negedge clk);
        frame_q.push_back(16'h0001);
        enable = 1'b1;
        wait_cs_fall(ok);
        vectors++; if (!ok || mcnt != 1) begin miscompares++; $display("FAIL reenable_phase: got found=%0d cnt=%0d want found=1 cnt=1", ok, mcnt); end
        wait_valid(ok);
        exp = 12'hxxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++; if (!ok || sample !== exp) begin miscompares++; $display("FAIL reenable_sample: got %h want %h", sample, exp); end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int nv;
        logic [11:0] exp;
        frame_q.push_back(16'h0FFF);
        wait_cs_fall(ok);
        for (int i = 0; i < 200 && mcnt != 40; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        vectors++; if (cs_n !== 1'b1) begin miscompares++; $display("FAIL midrst_cs_n: got %b want 1", cs_n); end
        vectors++; if (sclk !== 1'b1) begin miscompares++; $display("FAIL midrst_sclk: got %b want 1", sclk); end
        vectors++; if (sample !== 12'h000) begin miscompares++; $display("FAIL midrst_sample: got %h want 000", sample); end
        vectors++; if (valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid: got %b want 0", valid); end
        vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL midrst_frame_err: got %b want 0", ferr); end
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (valid) nv++;
        end
        vectors++; if (nv != 0) begin miscompares++; $display("FAIL midrst_no_strobe: got %0d strobes want 0", nv); end
        wait_valid(ok);
        exp = 12'hxxx;
        if (exp_q.size() > 0) exp = exp_q.pop_front();
        vectors++; if (!ok || sample !== exp) begin miscompares++; $display("FAIL post_rst_sample: got %h want %h", sample, exp); end
        vectors++; if (ferr !== 1'b0) begin miscompares++; $display("FAIL post_rst_frame_err: got %b want 0", ferr); end
        enable = 1'b0;
    endtask

    task automatic test_clkdiv1();
        bit ok;
        int low, rises, same;
        logic prev;
        logic [11:0] exp;
        frame_q2.push_back(16'h0A5C);
        enable2 = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!cs_n2) begin
                ok = 1'b1;
                break;
            end
        end
        enable2 = 1'b0;
        low = 1; rises = 0; same = 0; prev = sclk2;
        for (int i = 0; i < 200 && ok; i++) begin
            @(negedge clk);
            if (cs_n2) break;
            low++;
            if (sclk2 && !prev) rises++;
            if (sclk2 == prev) same++;
            prev = sclk2;
        end
        vectors++; if (!ok || low != 33) begin miscompares++; $display("FAIL div1_cs_low: got %0d want 33", low); end
        vectors++; if (rises != 16) begin miscompares++; $display("FAIL div1_rises: got %0d want 16", rises); end
        vectors++; if (same != 0) begin miscompares++; $display("FAIL div1_toggle: got %0d held cycles want 0", same); end
        vectors++; if (valid2 !== 1'b1) begin miscompares++; $display("FAIL div1_valid: got %b want 1", valid2); end
        exp = 12'hxxx;
        if (exp_q2.size() > 0) exp = exp_q2.pop_front();
        vectors++; if (sample2 !== exp) begin miscompares++; $display("FAIL div1_sample: got %h want %h", sample2, exp); end
        vectors++; if (ferr2 !== 1'b0) begin miscompares++; $display("FAIL div1_frame_err: got %b want 0", ferr2); end
    endtask

    initial begin
        test_reset();
        test_frame_timing();
        test_samples();
        test_frame_err();
        test_enable_midframe();
        test_reset_midframe();
        test_clkdiv1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Upstream capture stage of the guitar input path.
- Drives a 12-bit serial SPI ADC (16-clock frame: 4 leading zeros, then 12 data bits MSB-first) at a fixed sample rate.
- Deserialises each frame and converts offset-binary to two's complement.
- Presents a 12-bit signed sample with a one-cycle valid strobe, which feeds signed_expand directly (operand_size = 12).

Parameters:
- sample_width, 12, data bits per conversion.
- lead_zeros, 4, leading zero bits preceding data in each frame.
- clk_div, 4, SCLK half-period in clk cycles (≥1).
- sample_period, 1042, clk cycles between frame starts; must be ≥ clk_div*(2*(lead_zeros+sample_width)+1)+2 (elaboration assertion).
- offset_binary, 1, 1 = invert MSB of raw word; 0 = pass raw word unchanged.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- enable  in  1  start new frames while high
- adc_miso  in  1  serial data from ADC
- adc_cs_n  out  1  chip select, active low
- adc_sclk  out  1  serial clock, idles high
- sample  out  sample_width  two's-complement sample
- sample_valid  out  1  one-cycle strobe, sample updated
- frame_err  out  1  sticky: a leading bit was nonzero

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: adc_cs_n=1, adc_sclk=1, sample=0, sample_valid=0, frame_err=0, state IDLE, period counter=0, shift register=0.
- Period counter:
  - Free-running 0..sample_period-1; wraps to 0.
  - A tick occurs when counter==0 and enable=1.
  - The counter runs regardless of state.
- FSM states and transitions:
  - IDLE: on tick go to SETUP; adc_cs_n falls on the next edge.
  - SETUP: adc_cs_n=0, adc_sclk=1 for clk_div cycles, then go to SHIFT.
  - SHIFT: repeats F = lead_zeros+sample_width times. Each bit holds adc_sclk low for clk_div cycles, then high for clk_div cycles. adc_miso is captured into the shift register (MSB-first) on the clk edge where adc_sclk is driven 0→1. After the high half of the last bit, go to DONE.
  - DONE: one cycle. adc_cs_n=1, sample registered from the shift register's low sample_width bits (MSB inverted if offset_binary), sample_valid=1. Then return to IDLE.
- Timing: adc_cs_n is low for exactly clk_div*(2F+1) cycles per frame (132 at defaults). sample_valid is high in the first cycle adc_cs_n is high again.
- Between frames, sample holds its last value and sample_valid=0.
- frame_err:
  - Set in DONE if any of the first lead_zeros captured bits was 1.
  - Cleared only by rst.
  - The sample is still emitted.
- Enable:
  - Sampled only at the tick.
  - Deasserting mid-frame completes the current frame, including the valid strobe; no further frames start.
  - Re-asserting starts at the next counter==0. No partial-period start.
- Reset mid-frame: everything returns to reset values on the next edge. No sample_valid. adc_cs_n high immediately after that edge.
- Missed tick: by the parameter constraint a tick cannot occur while busy. A tick seen outside IDLE is ignored (defensive).

Decomposition:
- Shared package adc_pkg holds:
  - enum frame_state_t {IDLE, SETUP, SHIFT, DONE};
  - localparam frame bits F;
  - function to_twos(raw, offset_binary).
- One sub-module, sclk_gen:
  - Half-period counter plus bit counter.
  - Outputs adc_sclk, rise-strobe (capture enable) and last_bit.
  - Keeps the FSM in adc_spi_capture small.

Test Plan:
- Reset, enable=1, clk_div=2, sample_period=100:
  - adc_cs_n falls one cycle after counter 0 and stays low 66 cycles.
  - 16 SCLK rising edges.
  - sample_valid pulses once per 100 cycles.
- ADC model returns raw 0x800, 0xFFF, 0x000, 0x7FF with offset_binary=1 → sample 0x000, 0x7FF, 0x800, 0xFFF respectively. Downstream signed_expand yields 0x0000, 0x07FF, 0xF800, 0xFFFF.
- Leading bits 0100 with data 0x123:
  - frame_err=1 after DONE, sample=0x923.
  - frame_err stays 1 for the following clean frames until rst.
- Deassert enable at cycle 30 of a frame → that frame completes with a valid strobe; no further adc_cs_n activity; re-enable → next frame starts at counter==0.
- Assert rst for 1 cycle at cycle 40 of a frame → next cycle adc_cs_n=1, adc_sclk=1, sample=0; no sample_valid for that frame.
- offset_binary=0, raw 0xA5C → sample 0xA5C. clk_div=1 → SCLK toggles every cycle, adc_cs_n low 33 cycles.
